multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the 32-bit RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory. It drives the three 2:1 datapath operand muxes: ALU-B source, writeback source and next-PC source. It also generates the PC, IR and register-file write strobes and keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32 core: steps FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction/data memory and drives datapath strobes and mux selects.
module multicycle_ctrl #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 alu_zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 reg_we,
  output logic                 alu_b_sel,
  output logic                 wb_sel,
  output logic                 pc_sel,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // BEQ and BNE are separate classes so EXEC never looks at funct3 combinationally.
  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BEQ, C_BNE
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t                 state_q, state_d;
  class_t                 class_q, class_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   uses_imm;

  assign uses_imm  = (class_q == C_I) || (class_q == C_LOAD) || (class_q == C_STORE);
  assign instret_d = instret_q + INSTRET_W'(retire);
  assign instret   = instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      class_q   <= C_R;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = 1'b0;
    pc_sel    = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (opcode)
          OP_R:     class_d = C_R;
          OP_I:     class_d = C_I;
          OP_LOAD:  class_d = C_LOAD;
          OP_STORE: class_d = C_STORE;
          OP_BRANCH: begin
            if (funct3 == 3'b000)      class_d = C_BEQ;
            else if (funct3 == 3'b001) class_d = C_BNE;
            else                       state_d = S_TRAP;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        alu_b_sel = uses_imm;
        case (class_q)
          C_BEQ, C_BNE: begin
            pc_we   = 1'b1;
            pc_sel  = (class_q == C_BEQ) ? alu_zero : ~alu_zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        alu_b_sel = 1'b1;
        dmem_req  = 1'b1;
        dmem_we   = (class_q == C_STORE);
        if (dmem_ready) begin
          if (class_q == C_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        wb_sel    = (class_q == C_LOAD);
        alu_b_sel = uses_imm;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (INSTRET_W=4 so the counter wrap is reachable).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic       alu_b_sel, wb_sel, pc_sel, retire, illegal;
  logic [3:0] instret;
  logic [10:0] outs;
  logic [3:0] exp_instret;
  int tests = 0;
  int fails = 0;

  // bit order: imem_req dmem_req dmem_we ir_we pc_we reg_we alu_b wb_sel pc_sel retire illegal
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we,
                 alu_b_sel, wb_sel, pc_sel, retire, illegal};

  localparam logic [10:0] O_FIDLE  = 11'b100_0000_0000;
  localparam logic [10:0] O_FRDY   = 11'b100_1000_0000;
  localparam logic [10:0] O_NONE   = 11'b000_0000_0000;
  localparam logic [10:0] O_ALUB   = 11'b000_0001_0000;
  localparam logic [10:0] O_BR_T   = 11'b000_0100_0110;
  localparam logic [10:0] O_BR_N   = 11'b000_0100_0010;
  localparam logic [10:0] O_MEML   = 11'b010_0001_0000;
  localparam logic [10:0] O_MEMS   = 11'b011_0001_0000;
  localparam logic [10:0] O_MEMS_D = 11'b011_0101_0010;
  localparam logic [10:0] O_WB_R   = 11'b000_0110_0010;
  localparam logic [10:0] O_WB_I   = 11'b000_0111_0010;
  localparam logic [10:0] O_WB_L   = 11'b000_0111_1010;
  localparam logic [10:0] O_TRAP   = 11'b000_0000_0001;

  multicycle_ctrl #(.INSTRET_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .reg_we(reg_we), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .pc_sel(pc_sel),
    .retire(retire), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    exp_instret = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (outs !== O_FIDLE) begin fails++; $display("FAIL reset_outs got %b want %b", outs, O_FIDLE); end
    tests++;
    if (instret !== 4'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret); end
  endtask

  task automatic test_r_after_reset;
    logic [10:0] exp [4] = '{O_FRDY, O_NONE, O_NONE, O_WB_R};
    opcode = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
      #1;
      tests++;
      if (outs !== exp[i]) begin fails++; $display("FAIL r_seq cyc %0d got %b want %b", i, outs, exp[i]); end
    end
    tests++;
    if (instret !== 4'd0) begin fails++; $display("FAIL r_instret_before got %0d want 0", instret); end
    exp_instret++;
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    tests++;
    if (instret !== 4'd1) begin fails++; $display("FAIL r_instret_after got %0d want 1", instret); end
  endtask

  task automatic test_i_fetch_wait;
    logic [10:0] exp [5] = '{O_FIDLE, O_FRDY, O_NONE, O_ALUB, O_WB_I};
    opcode = 7'b0010011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ready = (i != 0); dmem_ready = 1'b1;
      #1;
      tests++;
      if (outs !== exp[i]) begin fails++; $display("FAIL i_seq cyc %0d got %b want %b", i, outs, exp[i]); end
      if (i == 0) begin
        tests++;
        if (instret !== exp_instret) begin fails++; $display("FAIL i_instret got %0d want %0d", instret, exp_instret); end
      end
    end
    exp_instret++;
  endtask

  task automatic test_load_wait;
    logic [10:0] exp [8] = '{O_FRDY, O_NONE, O_ALUB, O_MEML, O_MEML, O_MEML, O_MEML, O_WB_L};
    opcode = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      imem_ready = 1'b1;
      dmem_ready = !(i >= 3 && i <= 5);
      #1;
      tests++;
      if (outs !== exp[i]) begin fails++; $display("FAIL load_seq cyc %0d got %b want %b", i, outs, exp[i]); end
      if (i == 0) begin
        tests++;
        if (instret !== exp_instret) begin fails++; $display("FAIL load_instret got %0d want %0d", instret, exp_instret); end
      end
    end
    exp_instret++;
  endtask

  task automatic test_store;
    logic [10:0] exp [4] = '{O_FRDY, O_NONE, O_ALUB, O_MEMS_D};
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_ready = 1'b1; dmem_ready = 1'b1;
      #1;
      tests++;
      if (outs !== exp[i]) begin fails++; $display("FAIL store_seq cyc %0d got %b want %b", i, outs, exp[i]); end
      if (i == 0) begin
        tests++;
        if (instret !== exp_instret) begin fails++; $display("FAIL store_instret got %0d want %0d", instret, exp_instret); end
      end
    end
    exp_instret++;
  endtask

  task automatic test_branch;
    logic [2:0]  f3   [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic        az   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [10:0] exec [4] = '{O_BR_T, O_BR_N, O_BR_N, O_BR_T};
    opcode = 7'b1100011;
    for (int c = 0; c < 4; c++) begin
      funct3 = f3[c]; alu_zero = az[c];
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        tests++;
        if (outs !== (i == 0 ? O_FRDY : (i == 1 ? O_NONE : exec[c]))) begin
          fails++;
          $display("FAIL branch case %0d cyc %0d got %b", c, i, outs);
        end
        if (i == 0) begin
          tests++;
          if (instret !== exp_instret) begin fails++; $display("FAIL branch_instret got %0d want %0d", instret, exp_instret); end
        end
      end
      exp_instret++;
    end
    funct3 = 3'b000;
  endtask

  task automatic test_trap;
    logic [6:0] op [2] = '{7'b1111111, 7'b1100011};
    logic [2:0] f3 [2] = '{3'b000, 3'b010};
    for (int c = 0; c < 2; c++) begin
      opcode = op[c]; funct3 = f3[c];
      for (int i = 0; i < 22; i++) begin
        @(negedge clk);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        tests++;
        if (outs !== (i == 0 ? O_FRDY : (i == 1 ? O_NONE : O_TRAP))) begin
          fails++;
          $display("FAIL trap case %0d cyc %0d got %b", c, i, outs);
        end
      end
      @(negedge clk);
      imem_ready = 1'b0; reset = 1'b1;
      #1;
      exp_instret = 4'd0;
      tests++;
      if (outs !== O_FIDLE) begin fails++; $display("FAIL trap_reset case %0d got %b want %b", c, outs, O_FIDLE); end
      tests++;
      if (instret !== exp_instret) begin fails++; $display("FAIL trap_reset_instret got %0d want 0", instret); end
      @(negedge clk);
      reset = 1'b0;
    end
    funct3 = 3'b000;
  endtask

  task automatic test_reset_mid_store;
    logic [10:0] exp [5] = '{O_FRDY, O_NONE, O_ALUB, O_MEMS, O_MEMS};
    opcode = 7'b0100011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ready = (i == 0); dmem_ready = 1'b0;
      #1;
      tests++;
      if (outs !== exp[i]) begin fails++; $display("FAIL rst_store_seq cyc %0d got %b want %b", i, outs, exp[i]); end
    end
    tests++;
    if (instret !== exp_instret) begin fails++; $display("FAIL rst_store_wait_instret got %0d want %0d", instret, exp_instret); end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (dmem_req !== 1'b0 || outs !== O_FIDLE) begin
      fails++;
      $display("FAIL rst_store_async got %b want %b", outs, O_FIDLE);
    end
    tests++;
    if (instret !== 4'd0) begin fails++; $display("FAIL rst_store_instret got %0d want 0", instret); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (outs !== O_FIDLE) begin fails++; $display("FAIL rst_store_restart got %b want %b", outs, O_FIDLE); end
    exp_instret = 4'd0;
  endtask

  task automatic test_instret_wrap;
    opcode = 7'b1100011; funct3 = 3'b000; alu_zero = 1'b1;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        imem_ready = 1'b1; dmem_ready = 1'b0;
        #1;
        if (i == 0) begin
          tests++;
          if (instret !== exp_instret) begin fails++; $display("FAIL wrap_count k %0d got %0d want %0d", k, instret, exp_instret); end
          if (k == 15) begin
            tests++;
            if (instret !== 4'hF) begin fails++; $display("FAIL wrap_full got %0d want 15", instret); end
          end
        end
        if (i == 2) begin
          tests++;
          if (outs !== O_BR_T) begin fails++; $display("FAIL wrap_exec k %0d got %b want %b", k, outs, O_BR_T); end
        end
      end
      exp_instret++;
    end
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    tests++;
    if (instret !== 4'd0) begin fails++; $display("FAIL wrap_zero got %0d want 0", instret); end
  endtask

  initial begin
    test_reset();
    test_r_after_reset();
    test_i_fetch_wait();
    test_load_wait();
    test_store();
    test_branch();
    test_trap();
    test_reset_mid_store();
    test_instret_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
